mac_accumulator: RTL and testbench

//  Downstream of the fixed-point multiplier: sums a stream of signed products into one
//  dot-product result per burst, delimited by in_last. Result is shifted by OUT_SHIFT,

---
 rtl/accel_pkg.sv | 19 +
 rtl/acc_narrow.sv | 31 +++
 rtl/mac_accumulator.sv | 78 +++++++
 tb/tb_mac_accumulator.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: default widths, accumulator FSM states and
// saturation bounds for signed narrowing stages.
package accel_pkg;
  localparam int PROD_WIDTH_DEF = 32;
  localparam int OUT_WIDTH_DEF  = 16;

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} mac_acc_state_t;

  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  localparam logic signed [63:0] SAT_MAX_DEF = sat_max(OUT_WIDTH_DEF);
  localparam logic signed [63:0] SAT_MIN_DEF = sat_min(OUT_WIDTH_DEF);
endpackage

// File: rtl/acc_narrow.sv
// Combinational arithmetic shift + narrowing of a wide signed sum.
// MAC_ACC_SATURATE_EN selects clamping; otherwise low bits wrap.
module acc_narrow
  import accel_pkg::*;
#(
  parameter int IN_W  = 38,
  parameter int SHIFT = 0,
  parameter int OUT_W = OUT_WIDTH_DEF
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);
  logic signed [IN_W-1:0] shifted;
  assign shifted = din >>> SHIFT;

`ifdef MAC_ACC_SATURATE_EN
  localparam logic signed [IN_W-1:0] MAXV = IN_W'(sat_max(OUT_W));
  localparam logic signed [IN_W-1:0] MINV = IN_W'(sat_min(OUT_W));

  always_comb begin
    dout = shifted[OUT_W-1:0];
    if (shifted > MAXV)      dout = MAXV[OUT_W-1:0];
    else if (shifted < MINV) dout = MINV[OUT_W-1:0];
  end
`else
  // Upper bits are intentionally dropped: two's-complement wrap.
  logic unused_hi;
  assign unused_hi = ^shifted[IN_W-1:OUT_W];
  assign dout      = shifted[OUT_W-1:0];
`endif
endmodule

// File: rtl/mac_accumulator.sv
// Sums signed products into one dot-product per burst (in_last or MAX_LEN),
// presenting the narrowed result on valid/ready. Narrowing mode: MAC_ACC_SATURATE_EN.
module mac_accumulator
  import accel_pkg::*;
#(
  parameter int PROD_WIDTH = PROD_WIDTH_DEF,
  parameter int MAX_LEN    = 64,
  parameter int ACC_WIDTH  = PROD_WIDTH + $clog2(MAX_LEN),
  parameter int OUT_SHIFT  = 0,
  parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
  parameter int CNT_W      = $clog2(MAX_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_trunc
);
  mac_acc_state_t              state;
  logic signed [ACC_WIDTH-1:0] acc, in_ext, sum_nx;
  logic [CNT_W-1:0]            count, cnt_nx;
  logic                        first, accept, done;
  logic signed [OUT_WIDTH-1:0] narrowed;

  assign in_ready = (state == ACCUM) | out_ready;
  assign accept   = in_valid & in_ready;
  assign in_ext   = {{(ACC_WIDTH-PROD_WIDTH){in_data[PROD_WIDTH-1]}}, in_data};
  assign sum_nx   = first ? in_ext : acc + in_ext;
  assign cnt_nx   = first ? CNT_W'(1) : count + CNT_W'(1);
  assign done     = in_last | (cnt_nx == CNT_W'(MAX_LEN));

  acc_narrow #(
    .IN_W  (ACC_WIDTH),
    .SHIFT (OUT_SHIFT),
    .OUT_W (OUT_WIDTH)
  ) u_narrow (
    .din  (sum_nx),
    .dout (narrowed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
      out_trunc <= 1'b0;
    end else begin
      if (state == HOLD && out_ready) begin
        out_valid <= 1'b0;
        state     <= ACCUM;
      end
      // A beat accepted while leaving HOLD always has first=1, so it opens a new burst.
      if (accept) begin
        acc   <= sum_nx;
        count <= cnt_nx;
        first <= 1'b0;
        if (done) begin
          out_data  <= narrowed;
          out_count <= cnt_nx;
          out_trunc <= ~in_last;
          out_valid <= 1'b1;
          first     <= 1'b1;
          state     <= HOLD;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed self-checking bench for mac_accumulator (MAX_LEN=4, OUT_WIDTH=16).
module tb_mac_accumulator;
  localparam int PW = 32;
  localparam int OW = 16;
  localparam int ML = 4;
  localparam int CW = $clog2(ML) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] in_data;
  logic          in_valid, in_last, in_ready;
  logic [OW-1:0] out_data;
  logic          out_valid, out_ready, out_trunc;
  logic [CW-1:0] out_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mac_accumulator #(.PROD_WIDTH(PW), .MAX_LEN(ML), .OUT_SHIFT(0), .OUT_WIDTH(OW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_trunc (out_trunc)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input logic last);
    in_data  = PW'(d);
    in_valid = 1'b1;
    in_last  = last;
    cyc();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int d, input int cnt, input logic tr);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"},  32'($signed(out_data)), d);
    chk({tag, "_count"}, 32'(out_count), cnt);
    chk({tag, "_trunc"}, 32'(out_trunc), 32'(tr));
  endtask

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    cyc(); cyc();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data",  32'(out_data), 0);
    chk("rst_count", 32'(out_count), 0);
    chk("rst_trunc", 32'(out_trunc), 0);
    chk("rst_inrdy", 32'(in_ready), 1);
    rst = 1'b0;
    cyc();

    // Basic burst 3,5,-2
    beat(3, 0);
    beat(5, 0);
    chk("b1_novalid", 32'(out_valid), 0);
    beat(-2, 1);
    chk_res("b1", 6, 3, 0);
    cyc();
    chk("b1_drain", 32'(out_valid), 0);

    // Backpressure: result 11 held while a last-beat 10 waits
    beat(7, 0);
    out_ready = 1'b0;
    beat(4, 1);
    in_data = PW'(10); in_valid = 1'b1; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_inrdy", 32'(in_ready), 0);
      chk("bp_data",  32'($signed(out_data)), 11);
      chk("bp_valid", 32'(out_valid), 1);
      cyc();
    end
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0; in_last = 1'b0;
    chk_res("bp_rel", 10, 1, 0);
    cyc();
    chk("bp_drain", 32'(out_valid), 0);

    // Back-to-back single-beat bursts
    beat(1, 1);
    chk_res("s1", 1, 1, 0);
    beat(2, 1);
    chk_res("s2", 2, 1, 0);
    beat(3, 1);
    chk_res("s3", 3, 1, 0);
    cyc();
    chk("s_drain", 32'(out_valid), 0);

    // Forced termination at MAX_LEN; fifth beat opens a new burst
    for (int i = 0; i < 4; i++) beat(1, 0);
    chk_res("trunc", 4, 4, 1);
    beat(1, 0);
    chk("trunc_next_valid", 32'(out_valid), 0);
    beat(2, 1);
    chk_res("trunc_next", 3, 2, 0);
    cyc();

    // Narrowing boundary
    beat(30000, 0);
    beat(30000, 1);
`ifdef MAC_ACC_SATURATE_EN
    chk_res("nar_pos", 32767, 2, 0);
`else
    chk_res("nar_pos", -5536, 2, 0);
`endif
    beat(-30000, 0);
    beat(-30000, 1);
`ifdef MAC_ACC_SATURATE_EN
    chk_res("nar_neg", -32768, 2, 0);
`else
    chk_res("nar_neg", 5536, 2, 0);
`endif
    cyc();

    // Reset mid-burst
    beat(9, 0);
    beat(9, 0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rstmid_valid", 32'(out_valid), 0);
    beat(7, 1);
    chk_res("rstmid", 7, 1, 0);
    cyc();

    // Reset while holding a result
    out_ready = 1'b0;
    beat(5, 1);
    chk("rsthold_pre", 32'(out_valid), 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rsthold_valid", 32'(out_valid), 0);
    chk("rsthold_data",  32'(out_data), 0);
    chk("rsthold_inrdy", 32'(in_ready), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
